aes_round_ctrl: RTL and testbench

Round sequencer and handshake controller for the iterative AES-256 encryption datapath. It accepts a key and triggers the key-expansion unit once, then accepts plaintext blocks. For each block it drives the datapath's load, round-enable and final-round controls, plus the round-key index into the key store. It holds the finished ciphertext until downstream accepts it. It sits between the stream interface and the one-round-per-cycle AES state register.

---
 rtl/aes_round_ctrl_if.sv | 31 +++
 rtl/aes_round_ctrl.sv | 116 +++++++++++
 tb/tb_aes_round_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - key, block, datapath and output handshake bundle for aes_round_ctrl
interface aes_round_ctrl_if;
    logic       key_valid_i;
    logic       key_ready_o;
    logic       key_start_o;
    logic       key_done_i;
    logic       key_loaded_o;
    logic       blk_valid_i;
    logic       blk_ready_o;
    logic       dp_load_o;
    logic       dp_round_en_o;
    logic       dp_final_o;
    logic [3:0] rk_idx_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       busy_o;

    modport slave (
        input  key_valid_i, key_done_i, blk_valid_i, out_ready_i,
        output key_ready_o, key_start_o, key_loaded_o, blk_ready_o,
               dp_load_o, dp_round_en_o, dp_final_o, rk_idx_o,
               out_valid_o, busy_o
    );

    modport master (
        output key_valid_i, key_done_i, blk_valid_i, out_ready_i,
        input  key_ready_o, key_start_o, key_loaded_o, blk_ready_o,
               dp_load_o, dp_round_en_o, dp_final_o, rk_idx_o,
               out_valid_o, busy_o
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES round sequencer; AES_CTRL_OVERLAP_EN lets a new block load on the output handshake
module aes_round_ctrl #(
    parameter int NR = 14
) (
    input  logic              clk_i,
    input  logic              rst_i,
    aes_round_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, KEXP, ROUND, FINAL, DONE} state_t;

    localparam logic [3:0] NR_L  = 4'(NR);
    localparam logic [3:0] NR_M1 = 4'(NR - 1);

    state_t     state_q, state_d;
    logic [3:0] r_q, r_d;
    logic       key_loaded_q, key_loaded_d;
    logic       key_start_q, key_start_d;

    logic       key_ready, blk_ready, dp_load, dp_round_en, dp_final, out_valid;
    logic [3:0] rk_idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            r_q          <= 4'd0;
            key_loaded_q <= 1'b0;
            key_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            key_loaded_q <= key_loaded_d;
            key_start_q  <= key_start_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        key_loaded_d = key_loaded_q;
        key_start_d  = 1'b0;
        key_ready    = 1'b0;
        blk_ready    = 1'b0;
        dp_load      = 1'b0;
        dp_round_en  = 1'b0;
        dp_final     = 1'b0;
        rk_idx       = 4'd0;
        out_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                // Ready is masked while reset is held so every output reads 0 in reset.
                key_ready = !rst_i;
                blk_ready = key_loaded_q && !bus.key_valid_i;
                if (bus.key_valid_i) begin
                    state_d      = KEXP;
                    key_loaded_d = 1'b0;
                    key_start_d  = 1'b1;
                end else if (bus.blk_valid_i && blk_ready) begin
                    dp_load = 1'b1;
                    r_d     = 4'd1;
                    state_d = ROUND;
                end
            end
            KEXP: begin
                if (bus.key_done_i) begin
                    state_d      = IDLE;
                    key_loaded_d = 1'b1;
                end
            end
            ROUND: begin
                dp_round_en = 1'b1;
                rk_idx      = r_q;
                r_d         = r_q + 4'd1;
                if (r_q == NR_M1) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                dp_round_en = 1'b1;
                dp_final    = 1'b1;
                rk_idx      = NR_L;
                r_d         = 4'd0;
                state_d     = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
`ifdef AES_CTRL_OVERLAP_EN
                // The next block loads while the finished ciphertext is being taken.
                blk_ready = bus.out_ready_i && !bus.key_valid_i;
                if (bus.blk_valid_i && blk_ready) begin
                    dp_load = 1'b1;
                    r_d     = 4'd1;
                    state_d = ROUND;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.key_ready_o   = key_ready;
    assign bus.key_start_o   = key_start_q;
    assign bus.key_loaded_o  = key_loaded_q;
    assign bus.blk_ready_o   = blk_ready;
    assign bus.dp_load_o     = dp_load;
    assign bus.dp_round_en_o = dp_round_en;
    assign bus.dp_final_o    = dp_final;
    assign bus.rk_idx_o      = rk_idx;
    assign bus.out_valid_o   = out_valid;
    assign bus.busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - self-checking bench for aes_round_ctrl: vector table, directed sequences, random vs age-based model
module tb_aes_round_ctrl;
    localparam int NR = 14;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    aes_round_ctrl_if bus ();

    aes_round_ctrl #(.NR(NR)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a key expansion is tracked by its age in cycles, a block by cycles since its load cycle.
    int m_kexp;
    int m_age;
    bit m_loaded;

    typedef struct {
        logic kv, kd, bv, ordy;
        logic e_kr, e_ks, e_kl, e_br, e_busy;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle();
        bit idle, br, acc, ren;
        int rk;
        if (rst) begin
            m_kexp = -1; m_age = -1; m_loaded = 0;
            chk("rst key_ready", bus.key_ready_o, 0);
            chk("rst key_start", bus.key_start_o, 0);
            chk("rst key_loaded", bus.key_loaded_o, 0);
            chk("rst blk_ready", bus.blk_ready_o, 0);
            chk("rst dp_load", bus.dp_load_o, 0);
            chk("rst round_en", bus.dp_round_en_o, 0);
            chk("rst final", bus.dp_final_o, 0);
            chk("rst rk_idx", bus.rk_idx_o, 0);
            chk("rst out_valid", bus.out_valid_o, 0);
            chk("rst busy", bus.busy_o, 0);
            return;
        end
        idle = (m_kexp < 0) && (m_age < 0);
        br   = idle && m_loaded && !bus.key_valid_i;
`ifdef AES_CTRL_OVERLAP_EN
        if (m_age > NR && bus.out_ready_i && !bus.key_valid_i) br = 1;
`endif
        acc = bus.blk_valid_i && br;
        ren = (m_age >= 1) && (m_age <= NR);
        rk  = ren ? m_age : 0;
        chk("m key_ready", bus.key_ready_o, 8'(idle));
        chk("m key_start", bus.key_start_o, 8'(m_kexp == 0));
        chk("m key_loaded", bus.key_loaded_o, 8'(m_loaded));
        chk("m blk_ready", bus.blk_ready_o, 8'(br));
        chk("m dp_load", bus.dp_load_o, 8'(acc));
        chk("m round_en", bus.dp_round_en_o, 8'(ren));
        chk("m final", bus.dp_final_o, 8'(m_age == NR));
        chk("m rk_idx", bus.rk_idx_o, 8'(rk));
        chk("m out_valid", bus.out_valid_o, 8'(m_age > NR));
        chk("m busy", bus.busy_o, 8'(!idle));
        if (idle) begin
            if (bus.key_valid_i) begin m_kexp = 0; m_loaded = 0; end
            else if (acc) m_age = 1;
        end else if (m_kexp >= 0) begin
            if (bus.key_done_i) begin m_kexp = -1; m_loaded = 1; end
            else m_kexp++;
        end else if (m_age <= NR) begin
            m_age++;
        end else if (bus.out_ready_i) begin
            m_age = acc ? 1 : -1;
        end
    endtask

    task automatic drive(input logic kv, input logic kd, input logic bv, input logic ordy);
        bus.key_valid_i = kv;
        bus.key_done_i  = kd;
        bus.blk_valid_i = bv;
        bus.out_ready_i = ordy;
    endtask

    // Called mid-cycle after explicit checks: run the model, then move to just after the next rising edge.
    task automatic adv();
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        #4;
        adv();
    endtask

    task automatic load_key();
        drive(1, 0, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 0, 0); tick();
    endtask

    initial begin
        vec_t tbl[8];
        int   pulses[$];
        int   n;

        checks = 0; errors = 0;
        m_kexp = -1; m_age = -1; m_loaded = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0);

        tbl[0] = '{1, 0, 0, 0,  1, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0,  0, 1, 0, 0, 1};
        tbl[2] = '{0, 0, 0, 0,  0, 0, 0, 0, 1};
        tbl[3] = '{0, 0, 0, 0,  0, 0, 0, 0, 1};
        tbl[4] = '{0, 0, 0, 0,  0, 0, 0, 0, 1};
        tbl[5] = '{0, 1, 0, 0,  0, 0, 0, 0, 1};
        tbl[6] = '{0, 0, 0, 0,  1, 0, 1, 1, 0};
        tbl[7] = '{0, 1, 0, 0,  1, 0, 1, 1, 0};

        // Reset state
        @(posedge clk); #1;
        tick();
        tick();
        rst = 1'b0;

        // Key load from the vector table
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].kv, tbl[i].kd, tbl[i].bv, tbl[i].ordy);
            #4;
            chk($sformatf("tbl%0d key_ready", i), bus.key_ready_o, tbl[i].e_kr);
            chk($sformatf("tbl%0d key_start", i), bus.key_start_o, tbl[i].e_ks);
            chk($sformatf("tbl%0d key_loaded", i), bus.key_loaded_o, tbl[i].e_kl);
            chk($sformatf("tbl%0d blk_ready", i), bus.blk_ready_o, tbl[i].e_br);
            chk($sformatf("tbl%0d busy", i), bus.busy_o, tbl[i].e_busy);
            adv();
        end

        // Single block, then 10 cycles of output backpressure
        for (int i = 0; i <= 26; i++) begin
            drive(0, 0, (i == 0) || (i >= 15 && i <= 24), (i == 25));
            #4;
            chk($sformatf("blk%0d dp_load", i), bus.dp_load_o, 8'(i == 0));
            chk($sformatf("blk%0d round_en", i), bus.dp_round_en_o, 8'(i >= 1 && i <= NR));
            chk($sformatf("blk%0d final", i), bus.dp_final_o, 8'(i == NR));
            chk($sformatf("blk%0d rk_idx", i), bus.rk_idx_o, 8'((i <= NR) ? i : 0));
            chk($sformatf("blk%0d out_valid", i), bus.out_valid_o, 8'(i >= NR + 1 && i <= 25));
            if (i >= 15 && i <= 24) chk($sformatf("blk%0d bp blk_ready", i), bus.blk_ready_o, 0);
            if (i == 26) chk("blk idle after handshake", bus.key_ready_o, 1);
            adv();
        end

        // Key and block together: key wins, block waits for the new key
        drive(1, 0, 1, 0);
        #4;
        chk("sim key_ready", bus.key_ready_o, 1);
        chk("sim blk_ready", bus.blk_ready_o, 0);
        chk("sim dp_load", bus.dp_load_o, 0);
        adv();
        for (int i = 1; i <= 3; i++) begin
            drive(0, (i == 3), 1, 0);
            #4;
            chk($sformatf("sim%0d key_loaded", i), bus.key_loaded_o, 0);
            chk($sformatf("sim%0d dp_load", i), bus.dp_load_o, 0);
            adv();
        end
        drive(0, 0, 1, 0);
        #4;
        chk("sim late key_loaded", bus.key_loaded_o, 1);
        chk("sim late dp_load", bus.dp_load_o, 1);
        adv();
        drive(0, 0, 0, 1);
        n = 0;
        while (bus.busy_o === 1'b1 && n < 40) begin tick(); n++; end
        chk("sim drain timeout", 8'(n >= 40), 0);

        // Reset while in ROUND at r=7
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 0, 0);
        for (int i = 1; i < 7; i++) tick();
        #4;
        chk("mid rk_idx before reset", bus.rk_idx_o, 7);
        rst = 1'b1;
        #1;
        chk("mid rst key_loaded", bus.key_loaded_o, 0);
        chk("mid rst round_en", bus.dp_round_en_o, 0);
        model_cycle();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            #4;
            chk($sformatf("post rst%0d out_valid", i), bus.out_valid_o, 0);
            adv();
        end

        // Streaming with blk_valid and out_ready held high
        load_key();
        drive(0, 0, 1, 1);
        for (int i = 0; i < 70; i++) begin
            #4;
            if (bus.out_valid_o === 1'b1) begin
                pulses.push_back(i);
`ifdef AES_CTRL_OVERLAP_EN
                chk("ovl dp_load with handshake", bus.dp_load_o, 1);
`else
                chk("noovl dp_load with handshake", bus.dp_load_o, 0);
`endif
            end
            adv();
        end
        chk("stream pulse count enough", 8'(pulses.size() >= 3), 1);
`ifdef AES_CTRL_OVERLAP_EN
        for (int i = 1; i < pulses.size(); i++)
            chk("ovl pulse period", 8'(pulses[i] - pulses[i-1]), 8'(NR + 1));
`endif

        // Random traffic against the model
        drive(0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(999) < 3);
            drive($urandom_range(99) < 4, $urandom_range(99) < 30,
                  $urandom_range(99) < 50, $urandom_range(99) < 60);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
